// File: rtl/core.sv
// rtl/core.sv - shared branch-prediction record types
//
// Purpose: record types exchanged between the branch predictor and the
// resolve logic, with reset constants for each.
//   branch_pred_fb_t : predictor feedback (valid, base_pc, branch_taken)
//   pred_entry_t     : one outstanding prediction (pc, taken, exec_alt)
// PCs are held at pc_max_width bits; blocks with a narrower pc_width
// zero-extend on the way in and truncate on the way out.
package core;

  localparam int pc_max_width = 64;

  typedef struct packed {
    logic                    valid;
    logic [pc_max_width-1:0] base_pc;
    logic                    branch_taken;
  } branch_pred_fb_t;

  typedef struct packed {
    logic [pc_max_width-1:0] pc;
    logic                    taken;
    logic                    exec_alt;
  } pred_entry_t;

  localparam branch_pred_fb_t branch_pred_fb_rst = '{valid: 1'b0, base_pc: '0, branch_taken: 1'b0};
  localparam pred_entry_t     pred_entry_rst     = '{pc: '0, taken: 1'b0, exec_alt: 1'b0};

endpackage

// File: rtl/branch_fifo.sv
// rtl/branch_fifo.sv - circular FIFO of outstanding predicted branches
//
// Purpose: holds pred_entry_t records in issue order. Head/tail pointers
// wrap naturally because depth is a power of two.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write one entry at the tail
//   pop             retire the head entry
//   flush           discard every entry, including one pushed this cycle
//   head_data       oldest entry (combinational read)
//   occupancy       entry count, 0..depth
//   full, empty     occupancy == depth / occupancy == 0
module branch_fifo
  import core::*;
#(
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  pred_entry_t              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output pred_entry_t              head_data,
  output logic [$clog2(depth):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] ptr_one   = aw'(1);
  localparam logic [aw:0]   cnt_one   = (aw + 1)'(1);
  localparam logic [aw:0]   cnt_depth = (aw + 1)'(depth);

  logic [aw-1:0] head_q, head_d;
  logic [aw-1:0] tail_q, tail_d;
  logic [aw:0]   count_q, count_d;
  pred_entry_t   mem_q [depth];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + ptr_one;
      if (pop)  head_d = head_q + ptr_one;
      if (push && !pop)      count_d = count_q + cnt_one;
      else if (pop && !push) count_d = count_q - cnt_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: pointers and count alone decide validity.
  // A push while full (paired with a pop) writes the slot being read out,
  // which is safe because head_data is sampled before the edge.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign occupancy = count_q;
  assign full      = (count_q == cnt_depth);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - in-order branch resolution against queued predictions
//
// Purpose: queues issued predictions, compares each in-order actual outcome
// with the oldest prediction, and produces registered predictor feedback
// plus a full-flush (mispredict) or alternate-path (alt_select) pulse.
// Optional build macro: BRANCH_RESOLVE_STATS_EN adds saturating 32-bit
// stat_resolved / stat_mispred counters and their output ports.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   en                              global enable; low freezes the queue
//   pred_valid/pred_ready           enqueue handshake
//   pred_pc/pred_taken/pred_exec_alt prediction record
//   res_valid/res_taken             outcome of the oldest outstanding branch
//   fb_valid/fb_base_pc/fb_branch_taken registered feedback, latency 1
//   mispredict/alt_select           one-cycle pulses, latency 1
//   occupancy                       queued entry count
//   underflow_err                   sticky: resolve seen with empty queue
module branch_resolve
  import core::*;
#(
  parameter int queue_depth = 8,
  parameter int pc_width    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         pred_valid,
  output logic                         pred_ready,
  input  logic [pc_width-1:0]          pred_pc,
  input  logic                         pred_taken,
  input  logic                         pred_exec_alt,
  input  logic                         res_valid,
  input  logic                         res_taken,
  output logic                         fb_valid,
  output logic [pc_width-1:0]          fb_base_pc,
  output logic                         fb_branch_taken,
  output logic                         mispredict,
  output logic                         alt_select,
  output logic [$clog2(queue_depth):0] occupancy,
  output logic                         underflow_err
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]                  stat_resolved,
  output logic [31:0]                  stat_mispred
`endif
);

  pred_entry_t     head;
  pred_entry_t     push_data;
  logic            fifo_full, fifo_empty;
  logic            push, pop, mismatch, flush;

  branch_pred_fb_t fb_q, fb_d;
  logic            mispredict_q, mispredict_d;
  logic            alt_select_q, alt_select_d;
  logic            underflow_q, underflow_d;

  always_comb begin
    pop      = en && res_valid && !fifo_empty;
    mismatch = pop && (res_taken != head.taken);
    flush    = mismatch && !head.exec_alt;
    // A pop frees the head slot in the same edge, so a push is accepted
    // even when full; pred_ready still advertises the pre-pop state.
    push     = en && pred_valid && (!fifo_full || pop);

    push_data          = pred_entry_rst;
    push_data.pc       = pc_max_width'(pred_pc);
    push_data.taken    = pred_taken;
    push_data.exec_alt = pred_exec_alt;

    fb_d       = fb_q;
    fb_d.valid = pop;
    if (pop) begin
      fb_d.base_pc      = head.pc;
      fb_d.branch_taken = res_taken;
    end
    mispredict_d = flush;
    alt_select_d = mismatch && head.exec_alt;
    underflow_d  = underflow_q || (en && res_valid && fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q         <= branch_pred_fb_rst;
      mispredict_q <= 1'b0;
      alt_select_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      fb_q         <= fb_d;
      mispredict_q <= mispredict_d;
      alt_select_q <= alt_select_d;
      underflow_q  <= underflow_d;
    end
  end

  branch_fifo #(
    .depth(queue_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pred_ready      = en && !fifo_full;
  // Valid/pulse outputs are masked so nothing is signalled while disabled.
  assign fb_valid        = fb_q.valid && en;
  assign fb_base_pc      = pc_width'(fb_q.base_pc);
  assign fb_branch_taken = fb_q.branch_taken;
  assign mispredict      = mispredict_q && en;
  assign alt_select      = alt_select_q && en;
  assign underflow_err   = underflow_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (pop && (stat_resolved_q != 32'hFFFF_FFFF))
      stat_resolved_d = stat_resolved_q + 32'd1;
    if (mismatch && (stat_mispred_q != 32'hFFFF_FFFF))
      stat_mispred_d = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed scoreboard bench for branch_resolve
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, en, pred_valid, pred_ready, pred_taken, pred_exec_alt;
  logic [31:0] pred_pc, fb_base_pc;
  logic        res_valid, res_taken, fb_valid, fb_branch_taken;
  logic        mispredict, alt_select, underflow_err;
  logic [3:0]  occupancy;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst(rst), .en(en),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_exec_alt(pred_exec_alt),
    .res_valid(res_valid), .res_taken(res_taken),
    .fb_valid(fb_valid), .fb_base_pc(fb_base_pc), .fb_branch_taken(fb_branch_taken),
    .mispredict(mispredict), .alt_select(alt_select),
    .occupancy(occupancy), .underflow_err(underflow_err)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        alt;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        misp;
    logic        alt;
  } exp_t;

  ent_t model[$];
  exp_t sb[$];
  logic exp_uf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("fb_valid", 64'(fb_valid), 64'(1'b1));
      chk("fb_base_pc", 64'(fb_base_pc), 64'(x.pc));
      chk("fb_branch_taken", 64'(fb_branch_taken), 64'(x.taken));
      chk("mispredict", 64'(mispredict), 64'(x.misp));
      chk("alt_select", 64'(alt_select), 64'(x.alt));
    end else begin
      chk("fb_valid_idle", 64'(fb_valid), 64'(1'b0));
      chk("mispredict_idle", 64'(mispredict), 64'(1'b0));
      chk("alt_select_idle", 64'(alt_select), 64'(1'b0));
    end
    chk("occupancy", 64'(occupancy), 64'(model.size()));
    chk("underflow_err", 64'(underflow_err), 64'(exp_uf));
  endtask

  // One clock of stimulus: drive, update the reference queue, then compare
  // the registered results one edge later.
  task automatic cyc(input logic e, input logic pv, input logic [31:0] pc, input logic pt,
                     input logic pa, input logic rv, input logic rt);
    ent_t h;
    exp_t x;
    logic popping, push_ok, flush;
    en = e; pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_exec_alt = pa;
    res_valid = rv; res_taken = rt;
    #1;
    chk("pred_ready", 64'(pred_ready), 64'(e && (model.size() < 8)));
    popping = e && rv && (model.size() > 0);
    push_ok = e && pv && ((model.size() < 8) || popping);
    flush   = 1'b0;
    if (e && rv && (model.size() == 0)) exp_uf = 1'b1;
    if (popping) begin
      h       = model.pop_front();
      x.pc    = h.pc;
      x.taken = rt;
      x.misp  = (rt != h.taken) && !h.alt;
      x.alt   = (rt != h.taken) && h.alt;
      flush   = x.misp;
      sb.push_back(x);
    end
    if (flush) model.delete();
    else if (push_ok) begin
      h.pc = pc; h.taken = pt; h.alt = pa;
      model.push_back(h);
    end
    @(posedge clk);
    #1;
    en = 1'b1; pred_valid = 1'b0; res_valid = 1'b0;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    pred_exec_alt = 1'b0; res_valid = 1'b0; res_taken = 1'b0; exp_uf = 1'b0;
    #12;
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_fb_valid", 64'(fb_valid), 64'(0));
    chk("rst_fb_base_pc", 64'(fb_base_pc), 64'(0));
    chk("rst_mispredict", 64'(mispredict), 64'(0));
    chk("rst_alt_select", 64'(alt_select), 64'(0));
    chk("rst_underflow", 64'(underflow_err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Correct prediction: feedback only.
    cyc(1, 1, 32'h100, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Mispredict without alternate path: full flush.
    cyc(1, 1, 32'h200, 0, 0, 0, 0);
    cyc(1, 1, 32'h204, 1, 0, 0, 0);
    cyc(1, 1, 32'h208, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);

    // Mispredict with alternate path: younger entries kept, then drained.
    cyc(1, 1, 32'h300, 0, 1, 0, 0);
    cyc(1, 1, 32'h304, 1, 0, 0, 0);
    cyc(1, 1, 32'h308, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 0);

    // Enqueue in the same cycle as a flushing mispredict is dropped.
    cyc(1, 1, 32'h400, 0, 0, 0, 0);
    cyc(1, 1, 32'h404, 1, 0, 1, 1);

    // Disabled cycles change nothing.
    cyc(1, 1, 32'h500, 1, 0, 0, 0);
    cyc(0, 1, 32'h504, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);

    // Fill, refuse when full, then enqueue+resolve with wrapping pointers.
    for (int i = 0; i < 8; i++) cyc(1, 1, 32'h1000 + 32'(4 * i), i[0], 0, 0, 0);
    cyc(1, 1, 32'h1F00, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 1, 32'h2000 + 32'(4 * k), k[1], 0, 1, model[0].taken);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 1, model[0].taken);

    // Resolve while empty: sticky underflow, no feedback.
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Mid-cycle reset with entries queued and pulses pending.
    for (int i = 0; i < 6; i++) cyc(1, 1, 32'h3000 + 32'(4 * i), 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_occupancy", 64'(occupancy), 64'(0));
    chk("midrst_fb_valid", 64'(fb_valid), 64'(0));
    chk("midrst_fb_base_pc", 64'(fb_base_pc), 64'(0));
    chk("midrst_fb_taken", 64'(fb_branch_taken), 64'(0));
    chk("midrst_alt_select", 64'(alt_select), 64'(0));
    chk("midrst_mispredict", 64'(mispredict), 64'(0));
    chk("midrst_underflow", 64'(underflow_err), 64'(0));
    model.delete(); sb.delete(); exp_uf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_pred_ready", 64'(pred_ready), 64'(1));
    cyc(1, 1, 32'h600, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter queue_depth, default 8, max outstanding predicted branches (power of two, >=2).
REQ-002 SHALL have parameter pc_width, default 32, branch PC width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  global enable; when low, no state changes and all valid/pulse outputs low.
REQ-006 SHALL have ports pred_valid, pred_ready  input/output  1 each  enqueue handshake for an issued prediction.
REQ-007 SHALL have ports pred_pc, pred_taken, pred_exec_alt  input  pc_width/1/1  prediction record to enqueue.
REQ-008 SHALL have ports res_valid, res_taken  input  1 each  in-order actual outcome of the oldest outstanding branch.
REQ-009 SHALL have ports fb_valid, fb_base_pc, fb_branch_taken  output  1/pc_width/1  predictor feedback (core::branch_pred_fb_t fields).
REQ-010 SHALL have ports mispredict, alt_select  output  1 each  one-cycle pulses: full flush, or switch to alternate path without flush.
REQ-011 SHALL have ports occupancy  output  clog2(queue_depth)+1  entry count; underflow_err  output  1  sticky error flag.

Function
REQ-012 SHALL hold predictions in a circular FIFO with head/tail pointers wrapping modulo queue_depth.
REQ-013 SHALL assert pred_ready combinationally iff en and occupancy < queue_depth; enqueue occurs when pred_valid && pred_ready.
REQ-014 SHALL, on res_valid with occupancy > 0, pop the head entry and compare res_taken with its stored pred_taken.
REQ-015 SHALL register feedback: fb_valid=1, fb_base_pc=head pc, fb_branch_taken=res_taken in the cycle after resolve (latency 1).
REQ-016 SHALL, on mismatch with exec_alt=0, pulse mispredict in the cycle after resolve and discard all remaining entries (occupancy 0).
REQ-017 SHALL, on mismatch with exec_alt=1, pulse alt_select instead of mispredict and keep younger entries.
REQ-018 SHALL, on match, pulse neither mispredict nor alt_select.
REQ-019 SHALL, on simultaneous enqueue and pop without flush, keep occupancy unchanged, including when full (pop frees the slot; pred_ready still reflects pre-pop occupancy).
REQ-020 SHALL, on simultaneous enqueue and flushing mispredict, drop the enqueued entry as well (it is younger).
REQ-021 SHALL, on res_valid with occupancy 0, ignore the resolve, produce no feedback, and set underflow_err until reset.
REQ-022 SHALL ignore pred_valid and res_valid while en is low, and lose no state.

Reset
REQ-023 SHALL, on rst asserted at any time, asynchronously clear pointers, occupancy, fb_valid, fb_base_pc, fb_branch_taken, mispredict, alt_select and underflow_err to 0.
REQ-024 SHALL discard all in-flight entries and pending pulses when rst is asserted mid-operation; pred_ready is 1 in the first enabled cycle after release.

Configuration
REQ-025 SHALL compile 32-bit saturating counters stat_resolved and stat_mispred (outputs) only when BRANCH_RESOLVE_STATS_EN is defined; the counters are reset to 0 and increment per resolve and per mispredict/alt_select.
REQ-026 SHALL omit the counter ports and logic entirely when BRANCH_RESOLVE_STATS_EN is undefined, with otherwise identical behaviour.

Structure
REQ-027 SHALL place the pred-entry record typedef (pc, taken, exec_alt) and its reset constant in package core next to branch_pred_fb_t.
REQ-028 SHALL implement storage as one sub-module, branch_fifo, with flush input; compare and pulse logic stays in branch_resolve.

Verification
REQ-029 SHALL cover: enqueue pc=0x100 taken=1, resolve taken=1 -> next cycle fb_valid=1, fb_base_pc=0x100, fb_branch_taken=1, no pulses.
REQ-030 SHALL cover: enqueue 3 entries (first taken=0, exec_alt=0), resolve taken=1 -> mispredict pulse, occupancy 0 next cycle.
REQ-031 SHALL cover: same as REQ-030 but exec_alt=1 -> alt_select pulse, occupancy 2.
REQ-032 SHALL cover: fill 8 entries -> pred_ready=0; enqueue+resolve together wraps pointers, occupancy stays 8, 20 iterations FIFO order intact.
REQ-033 SHALL cover: resolve while empty -> no fb_valid, underflow_err=1 until rst.
REQ-034 SHALL cover: assert rst with 5 entries mid-cycle -> all outputs 0 immediately, occupancy 0, pred_ready=1 after release.
